mem_loader: RTL and testbench
=============================

# mem_loader

Byte-stream-to-memory-bus initiator: collects a little-endian header (start address, word count) and payload bytes from a byte source and drives 32-bit word writes onto the SoC valid/ready memory interface. It is the master-side counterpart of the peripheral responders on that interface, such as the print/UART sink. It sits between a host byte channel (UART receiver or bench driver) and the SoC memory port, and loads program images before or alongside CPU execution.

## Interface
- stall_limit, 1024: max cycles a write may wait for mem_ready before abort (must be ≥1)
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  byte source has data
- in_data  in  8  byte value
- in_ready  out  1  loader accepts byte this cycle
- mem_valid  out  1  write request
- mem_instr  out  1  constant 0 (data access)
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF during a request, 4'h0 otherwise
- mem_rdata  in  32  unused, ignored
- mem_ready  in  1  responder completes request
- busy  out  1  header or payload in progress (state ≠ ADDR or byte count ≠ 0)
- done  out  1  one-cycle pulse after last word write accepted
- error  out  1  sticky stall-abort flag; cleared by reset or first accepted byte of next header

## Operation
- Byte accept: in_valid & in_ready at rising edge. Bytes assembled little-endian (first byte → [7:0]).
- States: ADDR, LEN, DATA, WRITE, DONE.
  - ADDR: in_ready=1; 4 bytes → base address; mem_addr register = {addr[31:2],2'b00}; → LEN.
  - LEN: in_ready=1; 4 bytes → remaining word count (32 bit). Count 0 → DONE, else → DATA.
  - DATA: in_ready=1; 4 bytes → wdata; after 4th → WRITE.
  - WRITE: in_ready=0, mem_valid=1, mem_wstrb=4'hF; addr/wdata stable until accepted. On mem_ready: addr += 4 (wraps mod 2^32), count −= 1; count becomes 0 → DONE, else → DATA.
  - DONE: done=1 for exactly one cycle, in_ready=0; → ADDR.
- Stall counter: clears on WRITE entry, increments each WRITE cycle with mem_ready=0. Reaching stall_limit with mem_ready=0 → mem_valid drops, error=1, remaining count discarded, → ADDR. mem_ready=1 in the same cycle the limit is reached → accepted normally, no error.
- in_valid while in_ready=0 is ignored (byte not consumed). mem_rdata never used.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after reset (state ADDR); mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0; byte index, count, stall counter = 0.
- Byte throughput: 1 byte/cycle in ADDR/LEN/DATA.
- 4th payload byte accepted at edge N → mem_valid=1 from cycle N+1.
- mem_ready sampled high at edge M → mem_valid=0 and in_ready=1 from cycle M+1 (no back-to-back requests); last word → done=1 in cycle M+1.
- Minimum cost per word: 4 byte cycles + 1 WRITE cycle when mem_ready is high immediately.
- Reset asserted mid-operation (any state, including WRITE with mem_valid=1): mem_valid drops at the next edge, all partial bytes/counts discarded; no done pulse.
- Abort: error and mem_valid=0 take effect in the cycle after the limit edge; error holds until cleared.

## Test plan
- Header addr 0x00000100, len 2, data 0x11223344, 0xAABBCCDD, mem_ready tied 1 → writes (0x100,0x11223344),(0x104,0xAABBCCDD), wstrb F, one done pulse, 5 cycles/word.
- Len 0 header → no mem_valid ever, done pulse 1 cycle after 8th header byte, back to ADDR.
- Address 0xFFFFFFFE, len 2, mem_ready delayed 3 cycles each → mem_addr 0xFFFFFFFC then 0x00000000; addr/wdata stable while waiting; in_ready=0 throughout WRITE.
- stall_limit=4, mem_ready held 0 → mem_valid high for exactly 4 cycles, then error=1, ADDR; next header's first byte clears error; mem_ready=1 exactly on the 4th cycle → no error.
- Reset pulsed while mem_valid=1 on second word → mem_valid=0 next cycle, no done; fresh header then loads correctly from byte 0.
- Random in_valid gaps (≈50% duty) with bytes offered during WRITE → no byte lost or duplicated; data compared against reference image.

Source files
------------

// File: rtl/mem_loader_if.sv
// Handshake bundle for the loader: byte stream in, 32-bit memory writes out.
// "master" is the loader's view; "slave" is the byte source plus the memory
// responder.
interface mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  in_valid, in_data, mem_rdata, mem_ready,
    output in_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output in_valid, in_data, mem_rdata, mem_ready,
    input  in_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_loader.sv
// Byte-stream to memory-bus loader. Collects a little-endian header
// (start address, word count), then payload words, and issues one 32-bit
// write per word. A write that waits stall_limit cycles without mem_ready
// is abandoned and flagged with a sticky error.
module mem_loader #(
  parameter int stall_limit = 1024
) (
  input  logic         clock,
  input  logic         reset,
  mem_loader_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {ADDR, LEN, DATA, WRITE, DONE} state_t;

  // Stall counter holds at most stall_limit-1 before an abort decision.
  localparam int SW = $clog2(stall_limit + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(stall_limit - 1);

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [31:0]   shift_reg, shift_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   count_reg, count_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [SW-1:0] stall_reg, stall_next;
  logic          error_reg, error_next;

  logic          in_ready_int;
  logic          accept;
  logic          last_byte;
  logic [31:0]   word;
  logic          unused_rdata;

  // The responder's read data has no meaning for a write-only initiator.
  assign unused_rdata = ^bus.mem_rdata;

  // Bytes are only taken while collecting header/payload and never in reset.
  assign in_ready_int = !reset && (state_reg == ADDR || state_reg == LEN || state_reg == DATA);
  assign accept       = bus.in_valid && in_ready_int;
  assign last_byte    = accept && (idx_reg == 2'd3);
  // New byte enters at the top, so after four bytes the first sits in [7:0].
  assign word         = {bus.in_data, shift_reg[31:8]};

  assign bus.in_ready  = in_ready_int;
  assign bus.mem_valid = (state_reg == WRITE);
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_wstrb = (state_reg == WRITE) ? 4'hF : 4'h0;
  assign busy          = (state_reg != ADDR) || (idx_reg != 2'd0);
  assign done          = (state_reg == DONE);
  assign error         = error_reg;

  // Next-state and datapath updates for the header/payload/write sequence.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    wdata_next = wdata_reg;
    stall_next = stall_reg;
    error_next = error_reg;

    if (accept) begin
      shift_next = word;
      idx_next   = idx_reg + 2'd1;
    end

    case (state_reg)
      ADDR: begin
        // The first byte of a new header clears a previous abort.
        if (accept && idx_reg == 2'd0) error_next = 1'b0;
        if (last_byte) begin
          addr_next  = {word[31:2], 2'b00};
          state_next = LEN;
        end
      end
      LEN: begin
        if (last_byte) begin
          count_next = word;
          state_next = (word == 32'd0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (last_byte) begin
          wdata_next = word;
          stall_next = '0;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // A ready on the limit cycle still wins over the abort.
        if (bus.mem_ready) begin
          addr_next  = addr_reg + 32'd4;
          count_next = count_reg - 32'd1;
          state_next = (count_reg == 32'd1) ? DONE : DATA;
        end else if (stall_reg == STALL_LAST) begin
          error_next = 1'b1;
          count_next = 32'd0;
          state_next = ADDR;
        end else begin
          stall_next = stall_reg + SW'(1);
        end
      end
      DONE: begin
        state_next = ADDR;
      end
      default: begin
        state_next = ADDR;
      end
    endcase
  end

  // State register; reset discards any partial header, payload or write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ADDR;
      idx_reg   <= 2'd0;
      shift_reg <= 32'd0;
      addr_reg  <= 32'd0;
      count_reg <= 32'd0;
      wdata_reg <= 32'd0;
      stall_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      wdata_reg <= wdata_next;
      stall_reg <= stall_next;
      error_reg <= error_next;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: expected writes are queued as payload
// is driven and popped when the loader's write is accepted.
module tb_mem_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, done, error;

  mem_loader_if bus();

  mem_loader #(.stall_limit(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ready_delay = 0;   // -1: never ready
  bit rand_ready = 1'b0;
  int wcnt = 0;
  int cur_delay = 0;
  logic [31:0] hold_addr, hold_data;
  int done_cnt = 0;
  int valid_cycles = 0;
  int accept_cnt = 0;
  int last_accept_cyc = 0;
  int prev_accept_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Responder plus write monitor; ready is decided before the accept check.
  always @(negedge clock) begin
    wr_t e;
    if (bus.mem_valid === 1'b1) begin
      if (wcnt == 0) begin
        cur_delay = rand_ready ? int'($urandom_range(0, 2)) : ready_delay;
        hold_addr = bus.mem_addr;
        hold_data = bus.mem_wdata;
      end else begin
        checks++;
        if (bus.mem_addr !== hold_addr || bus.mem_wdata !== hold_data ||
            bus.in_ready !== 1'b0 || bus.mem_wstrb !== 4'hF) begin
          errors++;
          $display("FAIL write_stable: addr %h data %h in_ready %b wstrb %h, required addr %h data %h in_ready 0 wstrb f",
                   bus.mem_addr, bus.mem_wdata, bus.in_ready, bus.mem_wstrb, hold_addr, hold_data);
        end
      end
      bus.mem_ready = (cur_delay >= 0) && (wcnt >= cur_delay);
      wcnt++;
      valid_cycles++;
    end else begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end
    if (done === 1'b1) done_cnt++;
    if (bus.mem_valid === 1'b1 && bus.mem_ready === 1'b1) begin
      prev_accept_cyc = last_accept_cyc;
      last_accept_cyc = cyc;
      accept_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data ||
            bus.mem_wstrb !== 4'hF || bus.mem_instr !== 1'b0) begin
          errors++;
          $display("FAIL write: addr %h data %h wstrb %h instr %b, required addr %h data %h wstrb f instr 0",
                   bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_instr, e.addr, e.data);
        end else begin
          $display("write addr %h data %h ok", e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    for (int g = 0; g < 8 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clock);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n <= 50) begin
      @(negedge clock);
      n++;
    end
    if (n > 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: in_ready %b, required 1 within 50 cycles", bus.in_ready);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_pct);
  endtask

  task automatic send_header(input logic [31:0] a, input logic [31:0] l, input int gap_pct);
    send_word(a, gap_pct);
    send_word(l, gap_pct);
  endtask

  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL done_timeout: done pulses %0d, required 1 within %0d cycles", done_cnt - base, budget);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_valid !== 1'b0 || bus.mem_instr !== 1'b0 ||
        bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_wstrb !== 4'h0 ||
        busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready %b valid %b instr %b addr %h wdata %h wstrb %h busy %b done %b error %b, required all 0",
               bus.in_ready, bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wdata,
               bus.mem_wstrb, busy, done, error);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: in_ready %b busy %b, required in_ready 1 busy 0", bus.in_ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int base, acc0;
    ready_delay = 0;
    base = done_cnt;
    acc0 = accept_cnt;
    push_exp(32'h0000_0100, 32'h1122_3344);
    push_exp(32'h0000_0104, 32'hAABB_CCDD);
    send_header(32'h0000_0100, 32'd2, 0);
    send_word(32'h1122_3344, 0);
    send_word(32'hAABB_CCDD, 0);
    wait_done(base, 50);
    repeat (3) @(negedge clock);
    checks++;
    if (done_cnt - base != 1 || accept_cnt - acc0 != 2) begin
      errors++;
      $display("FAIL basic_counts: done pulses %0d writes %0d, required 1 and 2", done_cnt - base, accept_cnt - acc0);
    end
    checks++;
    if (last_accept_cyc - prev_accept_cyc != 5) begin
      errors++;
      $display("FAIL basic_rate: cycles per word %0d, required 5", last_accept_cyc - prev_accept_cyc);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: pending %0d busy %b in_ready %b, required 0 0 1", exp_q.size(), busy, bus.in_ready);
    end
    $display("test_basic done");
  endtask

  task automatic test_len0;
    int vbase;
    vbase = valid_cycles;
    send_header(32'h0000_0500, 32'd0, 0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL len0_done: done %b, required 1 one cycle after last header byte", done);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_return: done %b in_ready %b busy %b, required 0 1 0", done, bus.in_ready, busy);
    end
    checks++;
    if (valid_cycles != vbase) begin
      errors++;
      $display("FAIL len0_novalid: mem_valid cycles %0d, required 0", valid_cycles - vbase);
    end
    $display("test_len0 done");
  endtask

  task automatic test_wrap;
    int base;
    ready_delay = 3;
    base = done_cnt;
    push_exp(32'hFFFF_FFFC, 32'h0102_0304);
    push_exp(32'h0000_0000, 32'hCAFE_F00D);
    send_header(32'hFFFF_FFFE, 32'd2, 0);
    send_word(32'h0102_0304, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_done(base, 100);
    repeat (2) @(negedge clock);
    checks++;
    if (done_cnt - base != 1 || exp_q.size() != 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL wrap_result: done pulses %0d pending %0d error %b, required 1 0 0", done_cnt - base, exp_q.size(), error);
    end
    checks++;
    if (last_accept_cyc - prev_accept_cyc != 8) begin
      errors++;
      $display("FAIL wrap_rate: cycles per word %0d, required 8", last_accept_cyc - prev_accept_cyc);
    end
    $display("test_wrap done");
  endtask

  task automatic test_stall;
    int vbase, dbase, n;
    ready_delay = -1;
    vbase = valid_cycles;
    dbase = done_cnt;
    send_header(32'h0000_0200, 32'd3, 0);
    send_word(32'h5566_7788, 0);
    n = 0;
    while (error !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (error !== 1'b1 || valid_cycles - vbase != 4) begin
      errors++;
      $display("FAIL stall_abort: error %b mem_valid cycles %0d, required 1 and 4", error, valid_cycles - vbase);
    end
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || done_cnt != dbase) begin
      errors++;
      $display("FAIL stall_idle: valid %b in_ready %b busy %b done pulses %0d, required 0 1 0 0",
               bus.mem_valid, bus.in_ready, busy, done_cnt - dbase);
    end
    ready_delay = 3;
    push_exp(32'h0000_0300, 32'h99AA_BBCC);
    send_byte(8'h00, 0);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: error %b, required 0 after first header byte", error);
    end
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_word(32'd1, 0);
    dbase = done_cnt;
    vbase = valid_cycles;
    send_word(32'h99AA_BBCC, 0);
    wait_done(dbase, 50);
    checks++;
    if (error !== 1'b0 || valid_cycles - vbase != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_edge: error %b mem_valid cycles %0d pending %0d, required 0 4 0",
               error, valid_cycles - vbase, exp_q.size());
    end
    $display("test_stall done");
  endtask

  task automatic test_reset_mid;
    int dbase;
    ready_delay = 0;
    dbase = done_cnt;
    push_exp(32'h0000_0400, 32'h0BAD_BEEF);
    send_header(32'h0000_0400, 32'd3, 0);
    send_word(32'h0BAD_BEEF, 0);
    @(negedge clock);
    ready_delay = -1;
    send_word(32'hDEAD_DEAD, 0);
    checks++;
    if (bus.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_valid: mem_valid %b, required 1 on second word", bus.mem_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.mem_valid !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid %b done %b in_ready %b, required 0 0 0", bus.mem_valid, done, bus.in_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.mem_addr !== 32'd0 ||
        error !== 1'b0 || done_cnt != dbase || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_after: in_ready %b busy %b addr %h error %b done pulses %0d pending %0d, required 1 0 0 0 0 0",
               bus.in_ready, busy, bus.mem_addr, error, done_cnt - dbase, exp_q.size());
    end
    ready_delay = 0;
    dbase = done_cnt;
    push_exp(32'h0000_0800, 32'h1234_5678);
    send_header(32'h0000_0800, 32'd1, 0);
    send_word(32'h1234_5678, 0);
    wait_done(dbase, 50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reload: pending %0d, required 0", exp_q.size());
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random;
    int dbase;
    logic [31:0] img [8];
    rand_ready = 1'b1;
    dbase = done_cnt;
    for (int i = 0; i < 8; i++) begin
      img[i] = $urandom;
      push_exp(32'h0000_1000 + 32'(4 * i), img[i]);
    end
    send_header(32'h0000_1000, 32'd8, 50);
    for (int i = 0; i < 8; i++) send_word(img[i], 50);
    wait_done(dbase, 2000);
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || error !== 1'b0 || done_cnt - dbase != 1) begin
      errors++;
      $display("FAIL random_image: pending %0d error %b done pulses %0d, required 0 0 1",
               exp_q.size(), error, done_cnt - dbase);
    end
    rand_ready = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hA5A5_5A5A;
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
